mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Load/store controller directly upstream of the synchronous data memory (256 x 32-bit words, combinational read, write on posedge clk).
- Converts CPU byte-addressed requests into word-memory accesses.
- Supports LB/LBU/LH/LHU/LW/SB/SH/SW. Sub-word stores are done by read-modify-write.
- Uses a req/busy/done handshake and flags misaligned accesses.

Parameters:
- S, 32, data word width (fixed at 32).
- L, 256, memory depth in words; memory word address width AW = $clog2(L).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset.
- req  input  1  request strobe; sampled only in IDLE.
- we  input  1  1 = store, 0 = load.
- size  input  2  00 = byte, 01 = halfword, 10 = word; 11 is treated as word.
- sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  input  32  byte address.
- wdata  input  32  store data, right-justified for sub-word stores.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.
- rdata  output  32  load result, held until the next load completes.
- misaligned  output  1  valid together with done.
- mem_a  output  AW  word address, addr[AW+1:2].
- mem_din  output  32  merged write data.
- mem_dout  input  32  memory read data (combinational from mem_a).
- mem_read  output  1  high in RD state.
- mem_write  output  1  high in WR state, gated by reset.

Behaviour:
- Reset (reset=0 at posedge): state goes to IDLE; busy, done, misaligned, mem_read and mem_write are 0; rdata is 0.
- mem_write = (state==WR) & reset. A reset sampled at a WR edge suppresses that write.
- Reset in any state aborts the operation. No done pulse is generated for an aborted operation.
- Acceptance: in IDLE with req=1, latch we, size, sign_ext, addr and wdata into internal registers. Later input changes have no effect on the accepted operation.
- While busy, req is ignored and never queued.
- Alignment check: halfword requires addr[0]=0; word requires addr[1:0]=00.
  - Misaligned request: IDLE -> DONE, misaligned=1, no memory read or write, rdata unchanged.
- Byte lanes are big-endian:
  - byte offset 0 = bits[31:24], offset 3 = bits[7:0];
  - halfword offset 0 = bits[31:16], offset 2 = bits[15:0].
- Address bits above AW+1 are ignored, so addresses wrap modulo 4*L bytes.
- FSM states: IDLE, RD, WR, DONE.
  - Load: IDLE -> RD -> DONE.
    - In RD, mem_a is driven from the latched address, and rdata is loaded at the RD->DONE edge with the selected lane, sign- or zero-extended to 32 bits.
    - size=10 ignores sign_ext.
  - Word store: IDLE -> WR -> DONE. mem_din = latched wdata.
  - Sub-word store: IDLE -> RD -> WR -> DONE.
    - In RD, capture mem_dout into a merge register.
    - In WR, mem_din = merge register with the target lane replaced by wdata[7:0] (byte) or wdata[15:0] (halfword). All other lanes are preserved.
  - DONE: done=1 for exactly one cycle, then IDLE.
    - misaligned is 1 only for a rejected request; otherwise 0.
- Latency (req sampled at edge 0):
  - load: done high during cycle 2;
  - word store: done high during cycle 2;
  - sub-word store: done high during cycle 3;
  - misaligned: done high during cycle 1.
- A new req may be accepted in the IDLE cycle that follows DONE.
- mem_a holds the latched word address from RD through DONE. In IDLE it holds the last value and has no side effect.

Test Plan:
- Word round trip: SW addr=0x00000010, wdata=0xDEADBEEF, then LW addr=0x10 -> memory word 4 = 0xDEADBEEF; rdata=0xDEADBEEF with done at cycle 2 of each operation; misaligned=0.
- Byte load extension: word 4 = 0x80FF7F01.
  - LB addr=0x11 -> rdata=0xFFFFFFFF.
  - LBU addr=0x11 -> rdata=0x000000FF.
  - LB addr=0x10 -> rdata=0xFFFFFF80.
  - LH addr=0x12 -> rdata=0x00007F01.
- Read-modify-write: word 4 = 0x11223344.
  - SB addr=0x13, wdata=0xAB -> word 4 = 0x112233AB, done at cycle 3.
  - SH addr=0x10, wdata=0xCAFE -> word 4 = 0xCAFE33AB.
- Misaligned: LW addr=0x12 and SH addr=0x21 -> done at cycle 1 with misaligned=1; mem_write never asserted; memory and rdata unchanged.
- Handshake: req held high continuously with changing addr -> each operation uses the address latched at acceptance; no acceptance while busy=1; back-to-back operations are separated by exactly one IDLE cycle.
- Reset mid-op: SB started, reset=0 sampled in WR -> no memory change, no done, state IDLE; the next LW after release returns the original word. Wrap check: LW addr=0x00000400 reads word 0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store controller in front of a word-addressed synchronous data memory.
// Byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests; sub-word stores use read-modify-write.
module mem_access_ctrl #(
  parameter int unsigned S = 32,
  parameter int unsigned L = 256,
  localparam int unsigned AW = $clog2(L)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic          sign_ext,
  input  logic [S-1:0]  addr,
  input  logic [S-1:0]  wdata,
  output logic          busy,
  output logic          done,
  output logic [S-1:0]  rdata,
  output logic          misaligned,
  output logic [AW-1:0] mem_a,
  output logic [S-1:0]  mem_din,
  input  logic [S-1:0]  mem_dout,
  output logic          mem_read,
  output logic          mem_write
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            sext_q, sext_d;
  logic [1:0]      off_q, off_d;
  logic [S-1:0]    wdata_q, wdata_d;
  logic [AW-1:0]   mem_a_q, mem_a_d;
  logic [S-1:0]    din_q, din_d;
  logic [S-1:0]    rdata_q, rdata_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            mis_q, mis_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic            req_misaligned;

  // Upper address bits only select beyond the memory and wrap away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[S-1:AW+2];

  // Replace the addressed big-endian lane of old_w with the low bits of wd.
  function automatic logic [S-1:0] merge_lane(input logic [S-1:0] old_w,
                                              input logic [S-1:0] wd,
                                              input logic [1:0]   sz,
                                              input logic [1:0]   off);
    logic [S-1:0] r;
    r = old_w;
    if (sz == SZ_BYTE) begin
      case (off)
        2'd0:    r[31:24] = wd[7:0];
        2'd1:    r[23:16] = wd[7:0];
        2'd2:    r[15:8]  = wd[7:0];
        default: r[7:0]   = wd[7:0];
      endcase
    end else if (sz == SZ_HALF) begin
      if (off[1]) r[15:0]  = wd[15:0];
      else        r[31:16] = wd[15:0];
    end else begin
      r = wd;
    end
    return r;
  endfunction

  // Select the addressed big-endian lane and extend it to a full word.
  function automatic logic [S-1:0] load_lane(input logic [S-1:0] w,
                                             input logic [1:0]   sz,
                                             input logic [1:0]   off,
                                             input logic         sx);
    logic [7:0]   b;
    logic [15:0]  h;
    logic [S-1:0] r;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    if (sz == SZ_BYTE)      r = sx ? {{24{b[7]}}, b}  : {24'd0, b};
    else if (sz == SZ_HALF) r = sx ? {{16{h[15]}}, h} : {16'd0, h};
    else                    r = w;
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    mem_a_d = mem_a_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    mis_d   = 1'b0;

    req_misaligned = ((size == SZ_HALF) && addr[0]) ||
                     (size[1] && (addr[1:0] != 2'b00));

    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          sext_d  = sign_ext;
          off_d   = addr[1:0];
          wdata_d = wdata;
          if (req_misaligned) begin
            state_d = DONE;
            mis_d   = 1'b1;
          end else begin
            mem_a_d = addr[AW+1:2];
            if (we && size[1]) begin
              din_d   = wdata;
              state_d = WR;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: begin
        // Stores merge the fetched word here; loads extract their lane.
        if (we_q) begin
          din_d   = merge_lane(mem_dout, wdata_q, size_q, off_q);
          state_d = WR;
        end else begin
          rdata_d = load_lane(mem_dout, size_q, off_q, sext_q);
          state_d = DONE;
        end
      end
      WR:      state_d = DONE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    rd_d   = (state_d == RD);
    wr_d   = (state_d == WR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      off_q   <= 2'b00;
      wdata_q <= '0;
      mem_a_q <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      mem_a_q <= mem_a_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign misaligned = mis_q;
  assign mem_a      = mem_a_q;
  assign mem_din    = din_q;
  assign mem_read   = rd_q;
  // A reset arriving on the write edge must suppress that write.
  assign mem_write  = wr_q & reset;

endmodule
